// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand forwarding unit: scoreboard entry
// layout, select encoding and select-width helper.
package fwd_pkg;

    // Scoreboard rd field is sized for the widest supported register address;
    // narrower addresses are zero-extended on insertion and comparison.
    localparam int FWD_MAX_ADDR_W = 8;

    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                      valid;
        logic [FWD_MAX_ADDR_W-1:0] rd;
        logic                      is_load;
    } sb_entry_t;

    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/forward_select_lane.sv
// One source operand lane: priority match against the scoreboard, operand
// mux and load-use hazard flag for that lane.
module forward_select_lane
    import fwd_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int SEL_W            = fwd_sel_width(DEPTH)
) (
    input  logic [REG_ADDR_W-1:0]   src_addr,
    input  logic [XLEN-1:0]         src_data,
    input  logic [DEPTH*XLEN-1:0]   stage_data,
    input  sb_entry_t [DEPTH-1:0]   entries,
    output logic [XLEN-1:0]         operand,
    output logic [SEL_W-1:0]        sel,
    output logic                    hazard
);

    logic [FWD_MAX_ADDR_W-1:0] addr_ext;
    logic                      found;

    assign addr_ext = FWD_MAX_ADDR_W'(src_addr);

    // Ascending scan with a found flag gives the youngest (lowest k) match priority.
    always_comb begin
        sel     = SEL_W'(FWD_SEL_REGFILE);
        operand = src_data;
        hazard  = 1'b0;
        found   = 1'b0;
        if (src_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && entries[k].valid && (entries[k].rd != '0) &&
                    (entries[k].rd == addr_ext)) begin
                    found   = 1'b1;
                    sel     = SEL_W'(k + 1);
                    operand = stage_data[k*XLEN +: XLEN];
                    hazard  = entries[k].is_load && (k < LOAD_READY_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// Execute-stage operand forwarding and load-use stall unit with its own
// in-flight scoreboard. Optional stall statistics counter under FWD_STATS_EN.
module operand_forward_unit
    import fwd_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int SEL_W            = fwd_sel_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issueValid,
    input  logic                        issueRegWrite,
    input  logic                        issueIsLoad,
    input  logic [REG_ADDR_W-1:0]       issueRd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddr,
    input  logic [NUM_SRC*XLEN-1:0]     srcData,
    input  logic [DEPTH*XLEN-1:0]       stageData,
    input  logic                        flush,
    output logic [NUM_SRC*XLEN-1:0]     operandOut,
    output logic [NUM_SRC*SEL_W-1:0]    fwdSel,
    output logic                        stall
`ifdef FWD_STATS_EN
   ,output logic [31:0]                 stallCount
`endif
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             issue_entry;
    logic [NUM_SRC-1:0]    lane_hazard;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        forward_select_lane #(
            .XLEN             (XLEN),
            .REG_ADDR_W       (REG_ADDR_W),
            .DEPTH            (DEPTH),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W)
        ) u_lane (
            .src_addr   (srcAddr[i*REG_ADDR_W +: REG_ADDR_W]),
            .src_data   (srcData[i*XLEN +: XLEN]),
            .stage_data (stageData),
            .entries    (entries),
            .operand    (operandOut[i*XLEN +: XLEN]),
            .sel        (fwdSel[i*SEL_W +: SEL_W]),
            .hazard     (lane_hazard[i])
        );
    end

    assign stall = issueValid && (|lane_hazard);

    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = issueValid && issueRegWrite;
        issue_entry.rd      = FWD_MAX_ADDR_W'(issueRd);
        issue_entry.is_load = issueIsLoad;
    end

    // Flush squashes both in-flight entries and the current issue; a stall
    // still advances older entries but inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            entries <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= stall ? '0 : issue_entry;
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall && !flush && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed self-checking bench for operand_forward_unit with default parameters.
module tb_operand_forward_unit;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int SEL_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            issueValid;
    logic            issueRegWrite;
    logic            issueIsLoad;
    logic [RA_W-1:0] issueRd;
    logic [2*RA_W-1:0] srcAddr;
    logic [2*XLEN-1:0] srcData;
    logic [2*XLEN-1:0] stageData;
    logic            flush;
    logic [2*XLEN-1:0] operandOut;
    logic [2*SEL_W-1:0] fwdSel;
    logic            stall;
`ifdef FWD_STATS_EN
    logic [31:0]     stallCount;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    operand_forward_unit dut (
        .clk           (clk),
        .reset         (reset),
        .issueValid    (issueValid),
        .issueRegWrite (issueRegWrite),
        .issueIsLoad   (issueIsLoad),
        .issueRd       (issueRd),
        .srcAddr       (srcAddr),
        .srcData       (srcData),
        .stageData     (stageData),
        .flush         (flush),
        .operandOut    (operandOut),
        .fwdSel        (fwdSel),
        .stall         (stall)
`ifdef FWD_STATS_EN
       ,.stallCount    (stallCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one issue cycle's inputs and lets the combinational paths settle.
    task automatic applyStimulus(input logic v, input logic wr, input logic ld, input logic [RA_W-1:0] rd,
                                 input logic [RA_W-1:0] s0, input logic [RA_W-1:0] s1,
                                 input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                                 input logic [XLEN-1:0] sd0, input logic [XLEN-1:0] sd1,
                                 input logic fl);
        issueValid    = v;
        issueRegWrite = wr;
        issueIsLoad   = ld;
        issueRd       = rd;
        srcAddr       = {s1, s0};
        srcData       = {d1, d0};
        stageData     = {sd1, sd0};
        flush         = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 5, 6, 32'h11, 32'h22, 32'h0, 32'h0, 0);
        checkOutput("reset_op0", operandOut[31:0], 32'h11);
        checkOutput("reset_op1", operandOut[63:32], 32'h22);
        checkOutput("reset_sel", fwdSel, 4'h0);
        checkOutput("reset_stall", stall, 1'b0);
`ifdef FWD_STATS_EN
        checkOutput("reset_count", stallCount, 32'd0);
`endif
        tick();

        // Back-to-back ALU forwarding from entry 0, then entry 1
        applyStimulus(1, 1, 0, 5, 1, 2, 32'h1, 32'h2, 32'h0, 32'h0, 0);
        checkOutput("b2b_pre_sel", fwdSel, 4'h0);
        tick();
        applyStimulus(1, 0, 0, 0, 5, 6, 32'h33, 32'h44, 32'hAAAA, 32'hDEAD, 0);
        checkOutput("b2b_op0", operandOut[31:0], 32'hAAAA);
        checkOutput("b2b_sel0", fwdSel[1:0], 2'd1);
        checkOutput("b2b_op1", operandOut[63:32], 32'h44);
        checkOutput("b2b_sel1", fwdSel[3:2], 2'd0);
        checkOutput("b2b_stall", stall, 1'b0);
        tick();
        applyStimulus(1, 0, 0, 0, 5, 0, 32'h33, 32'h0, 32'h1234, 32'hBBBB, 0);
        checkOutput("e1_op0", operandOut[31:0], 32'hBBBB);
        checkOutput("e1_sel0", fwdSel[1:0], 2'd2);
        tick();
        idle();

        // Priority: two writers of x5, youngest wins on both lanes
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 5, 5, 32'h55, 32'h66, 32'hB0, 32'hA0, 0);
        checkOutput("prio_op0", operandOut[31:0], 32'hB0);
        checkOutput("prio_sel0", fwdSel[1:0], 2'd1);
        checkOutput("prio_op1", operandOut[63:32], 32'hB0);
        tick();
        idle();
        idle();

        // Load-use: one stall cycle, then forward from entry 1
        applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 8, 7, 0, 32'h70, 32'h0, 32'hC0DE, 32'h0, 0);
        checkOutput("lu_stall", stall, 1'b1);
        checkOutput("lu_sel_during", fwdSel[1:0], 2'd1);
        tick();
        applyStimulus(1, 1, 0, 8, 7, 0, 32'h70, 32'h0, 32'h0, 32'h7777, 0);
        checkOutput("lu_stall_after", stall, 1'b0);
        checkOutput("lu_sel_after", fwdSel[1:0], 2'd2);
        checkOutput("lu_op_after", operandOut[31:0], 32'h7777);
        tick();
`ifdef FWD_STATS_EN
        checkOutput("lu_count", stallCount, 32'd1);
`endif
        idle();
        idle();

        // Stall gated by issueValid
        applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 7, 0, 32'h70, 32'h0, 32'h9, 32'h0, 0);
        checkOutput("gate_stall", stall, 1'b0);
        checkOutput("gate_sel", fwdSel[1:0], 2'd1);
        tick();
        idle();

        // x0 is never forwarded
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h5555, 32'h6666, 0);
        checkOutput("x0_sel", fwdSel, 4'h0);
        checkOutput("x0_op0", operandOut[31:0], 32'h0);
        tick();
        idle();
        idle();

        // Flush together with a stalling issue clears the scoreboard
        applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 9, 4, 0, 32'h40, 32'h0, 32'h4444, 32'h3333, 1);
        checkOutput("fl_stall_pre", stall, 1'b1);
        tick();
        applyStimulus(1, 0, 0, 0, 3, 4, 32'h30, 32'h40, 32'hEEEE, 32'hFFFF, 0);
        checkOutput("fl_sel", fwdSel, 4'h0);
        checkOutput("fl_op0", operandOut[31:0], 32'h30);
        checkOutput("fl_op1", operandOut[63:32], 32'h40);
        checkOutput("fl_stall", stall, 1'b0);
`ifdef FWD_STATS_EN
        checkOutput("fl_count", stallCount, 32'd1);
`endif
        tick();
        idle();
        idle();

        // Reset asserted mid-stall
        applyStimulus(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 8, 7, 0, 32'h70, 32'h0, 32'h0, 32'h0, 0);
        checkOutput("rs_stall_pre", stall, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1, 1, 0, 8, 7, 0, 32'h70, 32'h0, 32'h0, 32'h0, 0);
        checkOutput("rs_stall", stall, 1'b0);
        checkOutput("rs_sel", fwdSel, 4'h0);
        checkOutput("rs_op0", operandOut[31:0], 32'h70);
`ifdef FWD_STATS_EN
        checkOutput("rs_count", stallCount, 32'd0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
